multiply_wallace_pipelined: RTL and testbench

Parametrised, pipelined Wallace-tree multiplier: the next generation of the combinational 8×8 unsigned Wallace multiplier. It supports a configurable operand width and a per-transaction signed (two's-complement) or unsigned mode. Three register stages sit between a valid/ready input port and a valid/ready output port, giving one result per cycle with backpressure. It is a drop-in arithmetic unit for datapaths that need a registered, flow-controlled product.

---
 rtl/multiply_wallace_pipelined.sv | 184 ++++++++++++++++++
 tb/tb_multiply_wallace_pipelined.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_wallace_pipelined.sv
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Per-transaction signed (Baugh-Wooley) or unsigned mode.
// Valid/ready semantics: a transfer happens on a rising edge where valid && ready.
// The whole pipeline advances together when the output slot is free or being
// drained (adv); otherwise every stage holds, and in_ready = adv.
module multiply_wallace_pipelined #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     multiplicand_a,
   input  logic [WIDTH-1:0]     multiplier_b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int PW     = 2 * WIDTH;
   // Column height never exceeds WIDTH+2 during reduction (WIDTH pp bits plus
   // the Baugh-Wooley constant, then at most 2/3 of that plus incoming carries).
   localparam int MAXH   = WIDTH + 2;
   // Enough carry-save layers for the tallest column at WIDTH=32; layers past
   // convergence only pass bits through.
   localparam int LAYERS = 10;

   // Append one bit on top of a column stack.
   function automatic logic [MAXH-1:0] put_bit(input logic [MAXH-1:0] v, input int pos, input logic b);
      put_bit = v | ({{(MAXH-1){1'b0}}, b} << pos);
   endfunction

   // Stage registers
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_mode_q, s1_mode_d;
   logic             s2_valid_q, s2_valid_d;
   logic [PW-1:0]    s2_sum_q, s2_sum_d;
   logic [PW-1:0]    s2_carry_q, s2_carry_d;
   logic             out_valid_q, out_valid_d;
   logic [PW-1:0]    product_q, product_d;

   logic             adv;
   logic [PW-1:0]    red_sum;
   logic [PW-1:0]    red_carry;

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign product   = product_q;
   assign busy      = s1_valid_q | s2_valid_q | out_valid_q;

   // Partial-product array and Wallace carry-save reduction down to two rows.
   always_comb begin : reduce_blk
      logic [MAXH-1:0] col  [PW+1];
      logic [MAXH-1:0] ncol [PW+1];
      int              h    [PW+1];
      int              nh   [PW+1];
      logic [MAXH-1:0] grp;
      logic            pp;
      for (int c = 0; c <= PW; c++) begin
         col[c]  = '0;
         ncol[c] = '0;
         h[c]    = 0;
         nh[c]   = 0;
      end
      grp = '0;
      pp  = 1'b0;
      // Baugh-Wooley: terms with exactly one sign bit are inverted in signed mode.
      for (int i = 0; i < WIDTH; i++) begin
         for (int j = 0; j < WIDTH; j++) begin
            pp = s1_a_q[j] & s1_b_q[i];
            if (s1_mode_q && ((i == WIDTH-1) != (j == WIDTH-1)))
               pp = ~pp;
            col[i+j] = put_bit(col[i+j], h[i+j], pp);
            h[i+j]   = h[i+j] + 1;
         end
      end
      // Correction constants at columns WIDTH and 2*WIDTH-1 (signed only).
      col[WIDTH] = put_bit(col[WIDTH], h[WIDTH], s1_mode_q);
      h[WIDTH]   = h[WIDTH] + 1;
      col[PW-1]  = put_bit(col[PW-1], h[PW-1], s1_mode_q);
      h[PW-1]    = h[PW-1] + 1;
      // Each layer: full adders on triples, a half adder on a leftover pair,
      // columns of height <= 2 pass through. Carries out of column PW-1 drop.
      for (int l = 0; l < LAYERS; l++) begin
         for (int c = 0; c <= PW; c++) begin
            ncol[c] = '0;
            nh[c]   = 0;
         end
         for (int c = 0; c < PW; c++) begin
            if (h[c] > 2) begin
               for (int g = 0; g < MAXH / 3; g++) begin
                  if (3 * g + 2 < h[c]) begin
                     grp       = col[c] >> (3 * g);
                     ncol[c]   = put_bit(ncol[c], nh[c], grp[0] ^ grp[1] ^ grp[2]);
                     nh[c]     = nh[c] + 1;
                     ncol[c+1] = put_bit(ncol[c+1], nh[c+1],
                                         (grp[0] & grp[1]) | (grp[0] & grp[2]) | (grp[1] & grp[2]));
                     nh[c+1]   = nh[c+1] + 1;
                  end
               end
               grp = col[c] >> (3 * (h[c] / 3));
               if (h[c] % 3 == 2) begin
                  ncol[c]   = put_bit(ncol[c], nh[c], grp[0] ^ grp[1]);
                  nh[c]     = nh[c] + 1;
                  ncol[c+1] = put_bit(ncol[c+1], nh[c+1], grp[0] & grp[1]);
                  nh[c+1]   = nh[c+1] + 1;
               end else if (h[c] % 3 == 1) begin
                  ncol[c] = put_bit(ncol[c], nh[c], grp[0]);
                  nh[c]   = nh[c] + 1;
               end
            end else begin
               ncol[c] = ncol[c] | (col[c] << nh[c]);
               nh[c]   = nh[c] + h[c];
            end
         end
         for (int c = 0; c <= PW; c++) begin
            col[c] = ncol[c];
            h[c]   = nh[c];
         end
      end
      for (int c = 0; c < PW; c++) begin
         red_sum[c]   = col[c][0];
         red_carry[c] = col[c][1];
      end
   end

   // Next-state for all stages: load from predecessor on adv, otherwise hold.
   // The mode is fully folded into the two rows, so S2 does not carry it.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_mode_d   = s1_mode_q;
      s2_valid_d  = s2_valid_q;
      s2_sum_d    = s2_sum_q;
      s2_carry_d  = s2_carry_q;
      out_valid_d = out_valid_q;
      product_d   = product_q;
      if (adv) begin
         s1_valid_d  = in_valid;
         s1_a_d      = multiplicand_a;
         s1_b_d      = multiplier_b;
         s1_mode_d   = signed_mode;
         s2_valid_d  = s1_valid_q;
         s2_sum_d    = red_sum;
         s2_carry_d  = red_carry;
         out_valid_d = s2_valid_q;
         // product keeps its last value when a bubble reaches the output.
         if (s2_valid_q)
            product_d = s2_sum_q + s2_carry_q;
      end
   end

   // Pipeline registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_mode_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_sum_q    <= '0;
         s2_carry_q  <= '0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_mode_q   <= s1_mode_d;
         s2_valid_q  <= s2_valid_d;
         s2_sum_q    <= s2_sum_d;
         s2_carry_q  <= s2_carry_d;
         out_valid_q <= out_valid_d;
         product_q   <= product_d;
      end
   end

endmodule

// File: tb/tb_multiply_wallace_pipelined.sv
// Bench for multiply_wallace_pipelined. Three instances (WIDTH 4, 8, 13) share
// one control/handshake stream; each sees the low bits of the operand buses.
// Inputs change #1 after a rising edge; outputs are observed on the falling edge.
module tb_multiply_wallace_pipelined;

   // ---------------- clock / reset / signals ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid;
   logic        signed_mode;
   logic        out_ready;
   logic [12:0] a_in, b_in;

   logic        in_ready4, in_ready8, in_ready13;
   logic        out_valid4, out_valid8, out_valid13;
   logic        busy4, busy8, busy13;
   logic [7:0]  product4;
   logic [15:0] product8;
   logic [25:0] product13;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  exp4_q[$];
   logic [15:0] exp8_q[$];
   logic [25:0] exp13_q[$];

   multiply_wallace_pipelined #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .multiplicand_a(a_in[3:0]), .multiplier_b(b_in[3:0]), .signed_mode(signed_mode),
      .out_valid(out_valid4), .out_ready(out_ready), .product(product4), .busy(busy4));

   multiply_wallace_pipelined #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
      .multiplicand_a(a_in[7:0]), .multiplier_b(b_in[7:0]), .signed_mode(signed_mode),
      .out_valid(out_valid8), .out_ready(out_ready), .product(product8), .busy(busy8));

   multiply_wallace_pipelined #(.WIDTH(13)) dut13 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready13),
      .multiplicand_a(a_in), .multiplier_b(b_in), .signed_mode(signed_mode),
      .out_valid(out_valid13), .out_ready(out_ready), .product(product13), .busy(busy13));

   // Reference: plain integer multiply of the (optionally sign-extended) operands.
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
      longint sa, sb, m, p;
      m  = longint'(1) << w;
      sa = longint'(a) & (m - 1);
      sb = longint'(b) & (m - 1);
      if (sgn && sa >= m / 2) sa = sa - m;
      if (sgn && sb >= m / 2) sb = sb - m;
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   task automatic push_expected();
      exp4_q.push_back(8'(ref_mul(4, {19'd0, a_in}, {19'd0, b_in}, signed_mode)));
      exp8_q.push_back(16'(ref_mul(8, {19'd0, a_in}, {19'd0, b_in}, signed_mode)));
      exp13_q.push_back(26'(ref_mul(13, {19'd0, a_in}, {19'd0, b_in}, signed_mode)));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
      a_in = '0; b_in = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid8 !== 1'b0 || out_valid4 !== 1'b0 || out_valid13 !== 1'b0) begin
         n_errors++; $display("FAIL reset_out_valid: got %b%b%b required 000", out_valid4, out_valid8, out_valid13);
      end
      n_checks++;
      if (busy8 !== 1'b0 || busy4 !== 1'b0 || busy13 !== 1'b0) begin
         n_errors++; $display("FAIL reset_busy: got %b%b%b required 000", busy4, busy8, busy13);
      end
      n_checks++;
      if (product8 !== 16'h0 || product4 !== 8'h0 || product13 !== 26'h0) begin
         n_errors++; $display("FAIL reset_product: got %h %h %h required 0", product4, product8, product13);
      end
      n_checks++;
      if (in_ready8 !== 1'b1) begin
         n_errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready8);
      end
      step();
   endtask

   task automatic test_single_op();
      in_valid = 1'b1; a_in = 13'h0D; b_in = 13'h0B; signed_mode = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready8 !== 1'b1) begin
         n_errors++; $display("FAIL single_accept: in_ready %b required 1", in_ready8);
      end
      step();
      in_valid = 1'b0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid8 !== (t == 2)) begin
            n_errors++; $display("FAIL single_out_valid t=%0d: got %b required %b", t, out_valid8, (t == 2));
         end
         n_checks++;
         if (busy8 !== (t < 3)) begin
            n_errors++; $display("FAIL single_busy t=%0d: got %b required %b", t, busy8, (t < 3));
         end
         if (t == 2) begin
            n_checks++;
            if (product8 !== 16'h008F) begin
               n_errors++; $display("FAIL single_product: got %h required 008f", product8);
            end
         end
         step();
      end
   endtask

   task automatic test_corners();
      logic [7:0]  ca [6];
      logic [7:0]  cb [6];
      logic        cm [6];
      logic [15:0] ce [6];
      ca = '{8'hFF, 8'h00, 8'h01, 8'h80, 8'h80, 8'hFF};
      cb = '{8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'hFF};
      cm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ce = '{16'hFE01, 16'h0000, 16'h00FF, 16'h4000, 16'hC080, 16'h0001};
      out_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c < 6) begin
            in_valid = 1'b1; a_in = {5'd0, ca[c]}; b_in = {5'd0, cb[c]}; signed_mode = cm[c];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 3) begin
            n_checks++;
            if (out_valid8 !== 1'b1 || product8 !== ce[c-3]) begin
               n_errors++;
               $display("FAIL corner_%0d: out_valid %b product %h required 1 %h", c - 3, out_valid8, product8, ce[c-3]);
            end
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] opa [5];
      logic [7:0] opb [5];
      logic       opm [5];
      int acc = 0, got = 0, hold_left = 0, dup = 0;
      logic started = 1'b0;
      logic [15:0] e;
      for (int i = 0; i < 5; i++) begin
         opa[i] = 8'($urandom); opb[i] = 8'($urandom); opm[i] = 1'($urandom_range(0, 1));
      end
      exp4_q.delete(); exp8_q.delete(); exp13_q.delete();
      for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
         if (acc < 5) begin
            in_valid = 1'b1; a_in = {5'd0, opa[acc]}; b_in = {5'd0, opb[acc]}; signed_mode = opm[acc];
         end else begin
            in_valid = 1'b0;
         end
         if (!started && out_valid8) begin
            started = 1'b1; hold_left = 4;
         end
         out_ready = (hold_left > 0) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (hold_left > 0) begin
            n_checks++;
            if (in_ready8 !== 1'b0) begin
               n_errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready8);
            end
            n_checks++;
            if (out_valid8 !== 1'b1 || product8 !== exp8_q[0]) begin
               n_errors++; $display("FAIL bp_hold: out_valid %b product %h required 1 %h", out_valid8, product8, exp8_q[0]);
            end
            hold_left--;
         end
         if (out_valid8 && out_ready) begin
            e = exp8_q.pop_front();
            void'(exp4_q.pop_front()); void'(exp13_q.pop_front());
            n_checks++;
            if (product8 !== e) begin
               n_errors++; $display("FAIL bp_result_%0d: got %h required %h", got, product8, e);
            end
            got++;
         end
         if (in_valid && in_ready8) begin
            push_expected();
            acc++;
         end
         step();
      end
      n_checks++;
      if (got != 5) begin
         n_errors++; $display("FAIL bp_count: got %0d results required 5", got);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (out_valid8) dup++;
         step();
      end
      n_checks++;
      if (dup != 0) begin
         n_errors++; $display("FAIL bp_duplicate: got %0d extra results required 0", dup);
      end
      exp4_q.delete(); exp8_q.delete(); exp13_q.delete();
   endtask

   task automatic test_mid_reset();
      int seen = 0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; a_in = 13'($urandom); b_in = 13'($urandom); signed_mode = 1'($urandom_range(0, 1));
         step();
      end
      in_valid = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || out_valid4 !== 1'b0 || out_valid13 !== 1'b0) begin
         n_errors++; $display("FAIL midrst_clear: out_valid %b busy %b required 0 0", out_valid8, busy8);
      end
      step();
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (out_valid8 || out_valid4 || out_valid13 || busy8) seen++;
         step();
      end
      n_checks++;
      if (seen != 0) begin
         n_errors++; $display("FAIL midrst_ghost: got %0d cycles with activity required 0", seen);
      end
   endtask

   task automatic test_exhaustive_w4();
      logic [7:0] e;
      exp4_q.delete();
      out_ready = 1'b1;
      for (int c = 0; c < 515; c++) begin
         if (c < 512) begin
            in_valid = 1'b1; a_in = 13'(c % 16); b_in = 13'((c / 16) % 16); signed_mode = (c >= 256);
            exp4_q.push_back(8'(ref_mul(4, {19'd0, a_in}, {19'd0, b_in}, signed_mode)));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (c >= 3) begin
            e = exp4_q.pop_front();
            n_checks++;
            if (out_valid4 !== 1'b1 || product4 !== e) begin
               n_errors++; $display("FAIL exh4_%0d: out_valid %b product %h required 1 %h", c - 3, out_valid4, product4, e);
            end
         end
         step();
      end
   endtask

   task automatic test_random();
      int n_ops = 10000;
      int acc = 0;
      int cyc = 0;
      logic [7:0]  e4;
      logic [15:0] e8;
      logic [25:0] e13;
      exp4_q.delete(); exp8_q.delete(); exp13_q.delete();
      while ((acc < n_ops || exp8_q.size() > 0) && cyc < 60000) begin
         in_valid    = (acc < n_ops) && ($urandom_range(0, 3) != 0);
         a_in        = 13'($urandom);
         b_in        = 13'($urandom);
         signed_mode = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n_checks++;
         if (in_ready8 !== (!out_valid8 || out_ready) || in_ready4 !== in_ready8 || in_ready13 !== in_ready8) begin
            n_errors++; $display("FAIL rand_in_ready: got %b%b%b", in_ready4, in_ready8, in_ready13);
         end
         if (out_valid8 && out_ready) begin
            n_checks++;
            if (exp8_q.size() == 0) begin
               n_errors++; $display("FAIL rand_extra: unexpected result %h", product8);
            end else begin
               e4 = exp4_q.pop_front(); e8 = exp8_q.pop_front(); e13 = exp13_q.pop_front();
               if (product8 !== e8) begin
                  n_errors++; $display("FAIL rand_w8: got %h required %h", product8, e8);
               end
               n_checks++;
               if (out_valid4 !== 1'b1 || product4 !== e4) begin
                  n_errors++; $display("FAIL rand_w4: out_valid %b got %h required %h", out_valid4, product4, e4);
               end
               n_checks++;
               if (out_valid13 !== 1'b1 || product13 !== e13) begin
                  n_errors++; $display("FAIL rand_w13: out_valid %b got %h required %h", out_valid13, product13, e13);
               end
            end
         end
         if (in_valid && in_ready8) begin
            push_expected();
            acc++;
         end
         step();
         cyc++;
      end
      n_checks++;
      if (acc != n_ops || exp8_q.size() != 0) begin
         n_errors++; $display("FAIL rand_drain: accepted %0d pending %0d required %0d 0", acc, exp8_q.size(), n_ops);
      end
      in_valid = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_single_op();
      test_corners();
      test_backpressure();
      test_mid_reset();
      test_exhaustive_w4();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
